// File: rtl/compressor_pkg.sv
// Types and constants shared by the outmap stager and the compressor that consumes its window.
package compressor_pkg;

  localparam int unsigned OUTMAP_LANES = 16;
  localparam int unsigned BYTE_W       = 8;

  typedef logic [OUTMAP_LANES-1:0][BYTE_W-1:0] outmap_vec_t;
  typedef logic [4:0]                          lane_cnt_t;

endpackage

// File: rtl/outmap_window_rotator.sv
// Gathers 16 consecutive circular-store entries starting at the read index, bytes plus last flags.
module outmap_window_rotator
  import compressor_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 64
) (
  input  logic [BYTE_W-1:0]                 mem_data [DEPTH_BYTES],
  input  logic [DEPTH_BYTES-1:0]            mem_last,
  input  logic [$clog2(DEPTH_BYTES)-1:0]    rd_idx,
  output outmap_vec_t                       win_data,
  output logic [OUTMAP_LANES-1:0]           win_last
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  // Index arithmetic is AW bits wide so it wraps modulo DEPTH_BYTES by construction.
  always_comb begin
    win_data = '0;
    win_last = '0;
    for (int k = 0; k < OUTMAP_LANES; k++) begin
      win_data[k] = mem_data[rd_idx + AW'(k)];
      win_last[k] = mem_last[rd_idx + AW'(k)];
    end
  end

endmodule

// File: rtl/outmap_stager.sv
// Byte-granular staging buffer feeding the compressor a 16-lane window that never crosses a map.
// Optional retired-byte statistics ports are enabled by defining OUTMAP_STAGER_STATS_EN.
module outmap_stager
  import compressor_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  outmap_vec_t in_data,
  input  lane_cnt_t   in_num,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output outmap_vec_t outmap_data,
  output lane_cnt_t   outmap_data_valid_num,
  output logic        start,
  input  lane_cnt_t   valid_taken_num,
  output logic        take_err
`ifdef OUTMAP_STAGER_STATS_EN
  ,
  output logic [31:0] stat_bytes,
  output logic [31:0] stat_zero_bytes
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  typedef logic [AW:0] ptr_t;

  ptr_t rd_q, wr_q, rd_d, wr_d, cnt;
  logic start_pending_q, start_pending_d;
  logic take_err_q;

  logic [BYTE_W-1:0]       mem_data [DEPTH_BYTES];
  logic [DEPTH_BYTES-1:0]  mem_last;

  outmap_vec_t             win_data;
  logic [OUTMAP_LANES-1:0] win_last;

  logic      found;
  lane_cnt_t first_idx, valid_num, take, push_num;
  logic      push, pop_last;

  assign cnt = wr_q - rd_q;

  outmap_window_rotator #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_rotator (
    .mem_data (mem_data),
    .mem_last (mem_last),
    .rd_idx   (rd_q[AW-1:0]),
    .win_data (win_data),
    .win_last (win_last)
  );

  // First last-flag among the stored lanes; descending scan leaves the lowest match.
  always_comb begin
    found     = 1'b0;
    first_idx = '0;
    for (int k = OUTMAP_LANES - 1; k >= 0; k--) begin
      if (win_last[k] && (cnt > ptr_t'(k))) begin
        found     = 1'b1;
        first_idx = lane_cnt_t'(k);
      end
    end
  end

  always_comb begin
    if (found) begin
      valid_num = first_idx + 5'd1;
    end else if (cnt >= ptr_t'(OUTMAP_LANES)) begin
      valid_num = 5'd16;
    end else begin
      valid_num = 5'd0;
    end
  end

  always_comb begin
    outmap_data = '0;
    for (int k = 0; k < OUTMAP_LANES; k++) begin
      if (lane_cnt_t'(k) < valid_num) outmap_data[k] = win_data[k];
    end
  end

  assign outmap_data_valid_num = valid_num;
  assign start    = start_pending_q && (valid_num != 5'd0);
  assign take_err = take_err_q;
  assign in_ready = (ptr_t'(DEPTH_BYTES) - cnt) >= ptr_t'(OUTMAP_LANES);

  assign take     = (valid_taken_num > valid_num) ? valid_num : valid_taken_num;
  // The window ends at the first last flag, so retiring all of it retires that boundary byte.
  assign pop_last = found && (take == valid_num);
  assign push_num = (in_num > 5'd16) ? 5'd16 : in_num;
  assign push     = in_valid && in_ready && (push_num != 5'd0);

  always_comb begin
    rd_d = rd_q + ptr_t'(take);
    wr_d = push ? (wr_q + ptr_t'(push_num)) : wr_q;
    if (pop_last) begin
      start_pending_d = 1'b1;
    end else if (start) begin
      start_pending_d = 1'b0;
    end else begin
      start_pending_d = start_pending_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q            <= '0;
      wr_q            <= '0;
      start_pending_q <= 1'b1;
      take_err_q      <= 1'b0;
      mem_last        <= '0;
    end else begin
      rd_q            <= rd_d;
      wr_q            <= wr_d;
      start_pending_q <= start_pending_d;
      if (valid_taken_num > valid_num) take_err_q <= 1'b1;
      if (push) begin
        for (int k = 0; k < OUTMAP_LANES; k++) begin
          if (lane_cnt_t'(k) < push_num) begin
            mem_last[wr_q[AW-1:0] + AW'(k)] <= in_last && (lane_cnt_t'(k) == push_num - 5'd1);
          end
        end
      end
    end
  end

  // Byte payload needs no reset: only lanes covered by count are ever presented.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < OUTMAP_LANES; k++) begin
        if (lane_cnt_t'(k) < push_num) mem_data[wr_q[AW-1:0] + AW'(k)] <= in_data[k];
      end
    end
  end

`ifdef OUTMAP_STAGER_STATS_EN
  logic [31:0] stat_bytes_q, stat_zero_q;
  lane_cnt_t   zero_cnt;

  always_comb begin
    zero_cnt = '0;
    for (int k = 0; k < OUTMAP_LANES; k++) begin
      if ((lane_cnt_t'(k) < take) && (win_data[k] == '0)) zero_cnt = zero_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bytes_q <= '0;
      stat_zero_q  <= '0;
    end else begin
      stat_bytes_q <= stat_bytes_q + 32'(take);
      stat_zero_q  <= stat_zero_q + 32'(zero_cnt);
    end
  end

  assign stat_bytes      = stat_bytes_q;
  assign stat_zero_bytes = stat_zero_q;
`endif

endmodule

// File: tb/tb_outmap_stager.sv
// Directed plus randomized bench for outmap_stager against a byte-queue reference model.
module tb_outmap_stager;
  import compressor_pkg::*;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  outmap_vec_t in_data;
  lane_cnt_t   in_num;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  outmap_vec_t outmap_data;
  lane_cnt_t   outmap_data_valid_num;
  logic        start;
  lane_cnt_t   valid_taken_num;
  logic        take_err;
`ifdef OUTMAP_STAGER_STATS_EN
  logic [31:0] stat_bytes;
  logic [31:0] stat_zero_bytes;
`endif

  outmap_stager #(
    .DEPTH_BYTES (DEPTH)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_data               (in_data),
    .in_num                (in_num),
    .in_last               (in_last),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .outmap_data           (outmap_data),
    .outmap_data_valid_num (outmap_data_valid_num),
    .start                 (start),
    .valid_taken_num       (valid_taken_num),
    .take_err              (take_err)
`ifdef OUTMAP_STAGER_STATS_EN
    ,
    .stat_bytes            (stat_bytes),
    .stat_zero_bytes       (stat_zero_bytes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       l;
  } ent_t;

  ent_t        q[$];
  bit          m_pend;
  bit          m_err;
  int unsigned m_bytes;
  int unsigned m_zeros;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_vn();
    int n;
    n = (q.size() < 16) ? q.size() : 16;
    for (int k = 0; k < n; k++) begin
      if (q[k].l) return k + 1;
    end
    return (q.size() >= 16) ? 16 : 0;
  endfunction

  function automatic outmap_vec_t exp_data();
    outmap_vec_t v;
    int          n;
    v = '0;
    n = exp_vn();
    for (int k = 0; k < n; k++) v[k] = q[k].b;
    return v;
  endfunction

  task automatic check_outputs();
    int vn;
    vn = exp_vn();
    chk("valid_num", outmap_data_valid_num, vn);
    chk("start", start, m_pend && (vn != 0));
    chk("in_ready", in_ready, (DEPTH - q.size()) >= 16);
    chk("take_err", take_err, m_err);
    chk("data", outmap_data, exp_data());
`ifdef OUTMAP_STAGER_STATS_EN
    chk("stat_bytes", stat_bytes, m_bytes);
    chk("stat_zero_bytes", stat_zero_bytes, m_zeros);
`endif
  endtask

  function automatic outmap_vec_t rand_vec();
    outmap_vec_t v;
    for (int k = 0; k < 16; k++) v[k] = 8'($urandom);
    return v;
  endfunction

  // One clock: drive at negedge, compare, then advance the model at the posedge.
  task automatic step(input outmap_vec_t d, input int num, input bit last, input bit val,
                      input int taken);
    int   vn;
    int   tk;
    bit   st;
    bit   rdy;
    bit   popped_last;
    ent_t e;
    @(negedge clk);
    in_data         = d;
    in_num          = lane_cnt_t'(num);
    in_last         = last;
    in_valid        = val;
    valid_taken_num = lane_cnt_t'(taken);
    check_outputs();
    vn  = exp_vn();
    st  = m_pend && (vn != 0);
    rdy = (DEPTH - q.size()) >= 16;
    @(posedge clk);
    tk = (taken < vn) ? taken : vn;
    if (taken > vn) m_err = 1'b1;
    popped_last = 1'b0;
    for (int k = 0; k < tk; k++) begin
      e = q.pop_front();
      if (e.l) popped_last = 1'b1;
      m_bytes++;
      if (e.b == 8'h00) m_zeros++;
    end
    if (popped_last) m_pend = 1'b1;
    else if (st) m_pend = 1'b0;
    if (val && rdy && (num != 0)) begin
      for (int k = 0; k < num; k++) q.push_back('{b: d[k], l: last && (k == num - 1)});
    end
    #1;
    in_valid        = 1'b0;
    valid_taken_num = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      if (exp_vn() == 0) step(rand_vec(), 1, 1'b1, 1'b1, 0);
      else step('0, 0, 1'b0, 1'b0, exp_vn());
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend  = 1'b1;
    m_err   = 1'b0;
    m_bytes = 0;
    m_zeros = 0;
  endtask

  initial begin
    outmap_vec_t d1;
    outmap_vec_t d2;
    int          vn;
    int          num;
    int          taken;
    int          r;
    total = 0;
    bad   = 0;
    model_reset();
    rst_n           = 1'b0;
    in_data         = '0;
    in_num          = '0;
    in_last         = 1'b0;
    in_valid        = 1'b0;
    valid_taken_num = '0;

    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_valid_num", outmap_data_valid_num, 0);
    chk("rst_start", start, 1'b0);
    chk("rst_take_err", take_err, 1'b0);
    chk("rst_data", outmap_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full 16-byte chunk without boundary: presented next cycle with a one-cycle start.
    d1 = rand_vec();
    step(d1, 16, 1'b0, 1'b1, 0);
    chk("tp1_vn", outmap_data_valid_num, 16);
    chk("tp1_start", start, 1'b1);
    chk("tp1_lane0", outmap_data[0], d1[0]);
    step('0, 0, 1'b0, 1'b0, 0);
    chk("tp1_start_once", start, 1'b0);

    // Map closing at 10 bytes, then start again on the following map.
    step(rand_vec(), 10, 1'b1, 1'b1, 16);
    chk("tp2_vn10", outmap_data_valid_num, 10);
    step(rand_vec(), 16, 1'b0, 1'b1, 10);
    chk("tp2_vn16", outmap_data_valid_num, 16);
    chk("tp2_start", start, 1'b1);
    step('0, 0, 1'b0, 1'b0, 16);
    chk("tp2_empty_vn", outmap_data_valid_num, 0);

    // Partial map stalls until 16 bytes are present.
    step(rand_vec(), 8, 1'b0, 1'b1, 0);
    chk("tp3_stall", outmap_data_valid_num, 0);
    d2 = rand_vec();
    step(d2, 8, 1'b0, 1'b1, 0);
    chk("tp3_vn", outmap_data_valid_num, 16);
    chk("tp3_lane8", outmap_data[8], d2[0]);
    chk("tp3_lane15", outmap_data[15], d2[7]);

    // Fill to 56, refuse a push while not ready, recover after a 16-byte take.
    step(rand_vec(), 16, 1'b0, 1'b1, 0);
    step(rand_vec(), 16, 1'b0, 1'b1, 0);
    step(rand_vec(), 8, 1'b0, 1'b1, 0);
    chk("tp4_not_ready", in_ready, 1'b0);
    step(rand_vec(), 16, 1'b1, 1'b1, 16);
    chk("tp4_ready", in_ready, 1'b1);
    drain();

    // Reset mid-operation discards buffered bytes immediately.
    step(rand_vec(), 12, 1'b1, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_vn", outmap_data_valid_num, 0);
    chk("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Six zero bytes among sixteen retired.
    d1 = rand_vec();
    for (int k = 0; k < 16; k++) d1[k] = d1[k] | 8'h01;
    d1[0] = 8'h00; d1[3] = 8'h00; d1[4] = 8'h00;
    d1[9] = 8'h00; d1[12] = 8'h00; d1[15] = 8'h00;
    step(d1, 16, 1'b0, 1'b1, 0);
    step('0, 0, 1'b0, 1'b0, 16);
`ifdef OUTMAP_STAGER_STATS_EN
    chk("stats_bytes16", stat_bytes, 16);
    chk("stats_zero6", stat_zero_bytes, 6);
`endif

    // Over-take: only the presented 5 retire and the error is sticky.
    step(rand_vec(), 5, 1'b1, 1'b1, 0);
    chk("tp5_vn5", outmap_data_valid_num, 5);
    step('0, 0, 1'b0, 1'b0, 9);
    chk("tp5_err", take_err, 1'b1);
    chk("tp5_empty", outmap_data_valid_num, 0);
    d1 = rand_vec();
    step(d1, 3, 1'b1, 1'b1, 0);
    chk("tp5_after_lane0", outmap_data[0], d1[0]);
    chk("tp5_err_sticky", take_err, 1'b1);
    drain();

    for (int i = 0; i < 600; i++) begin
      vn  = exp_vn();
      num = $urandom_range(0, 16);
      r   = $urandom_range(0, 19);
      if (r < 13) taken = $urandom_range(0, vn);
      else if (r < 19) taken = $urandom_range(0, 16);
      else taken = $urandom_range(0, 31);
      step(rand_vec(), num, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, taken);
    end
    @(negedge clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
